io_responder: RTL and testbench
===============================

IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 Parameter BASE_ADDR, default 8'hF0: I/O window base; bits [7:3] match, bits [2:0] select register.
REQ-002 Parameter SYNC_STAGES, default 2: input synchronizer depth, minimum 2.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 io_en  input  1  CPU I/O-cycle qualifier (iom micro-bit).
REQ-006 io_wr  input  1  CPU write/read-n during I/O cycle.
REQ-007 io_addr  input  8  CPU I/O address.
REQ-008 io_wdata  input  8  CPU write data.
REQ-009 io_rdata  output  8  read data returned to CPU data input.
REQ-010 int_req  output  1  interrupt pulse to CPU interrupt-enable input.
REQ-011 gpio_in  input  8  asynchronous external inputs.
REQ-012 gpio_out  output  8  registered external outputs.

Function
REQ-013 sel = io_en & (io_addr[7:3] == BASE_ADDR[7:3]); register map by io_addr[2:0]: 0 PORT_OUT RW, 1 PORT_IN RO, 2 EDGE_STAT R/W1C, 3 EDGE_MASK RW, 4 TMR_RELOAD RW, 5 TMR_CTRL RW (bit0 run, bit1 auto-reload, bit2 timer irq enable, bits7:3 read 0), 6 TMR_COUNT RO, 7 IRQ_STAT R/W1C (bit0 timer flag, bit1 edge summary RO).
REQ-014 io_rdata combinational from sel and io_addr when io_wr=0; 8'h00 when not selected or io_wr=1.
REQ-015 Write commits exactly once per access: on the first cycle of sel & io_wr (write strobe edge-detected against the previous cycle); holding strobe for further cycles has no effect.
REQ-016 Writes to RO registers ignored; no side effects on reads.
REQ-017 PORT_IN = gpio_in after SYNC_STAGES flops; value visible to reads SYNC_STAGES cycles after pin change.
REQ-018 EDGE_STAT[i] sets on synchronized rising edge of gpio_in[i]; W1C clears; simultaneous set and clear on same bit: set wins.
REQ-019 Timer: 8-bit down-counter; writing TMR_RELOAD also loads TMR_COUNT; when run=1 decrements by 1 per clk; at count==0 with run=1: set timer flag, then reload if auto-reload=1, else clear run and hold 0.
REQ-020 Timer flag set and W1C in same cycle: set wins.
REQ-021 Writing TMR_CTRL run=1 with count==0 and auto-reload=0 sets flag next cycle and stops.
REQ-022 irq_pending = (timer flag & irq enable) | (|(EDGE_STAT & EDGE_MASK)); IRQ_STAT bit1 = second term.
REQ-023 int_req is a registered one-cycle pulse on each 0->1 transition of irq_pending; stays low while pending stays high.
REQ-024 gpio_out is PORT_OUT register, updated one cycle after write commit.

Reset
REQ-025 rst low asynchronously clears all registers, synchronizer flops, strobe history, timer and pulse flop: gpio_out=8'h00, io_rdata=8'h00, int_req=0, TMR_COUNT=0, run=0.
REQ-026 Reset mid-count aborts timer; no int_req on reset release; first synchronized edges after release only count after SYNC_STAGES cycles.

Structure
REQ-027 Shared package io_pkg holds register offset constants, TMR_CTRL bit positions and IRQ_STAT bit positions.
REQ-028 Timer in one sub-module io_timer (reload, run, auto-reload, count, expire flag); synchronizer/edge logic and decode stay in top.

Verification
REQ-029 Write 8'hA5 to 0xF0, read 0xF0 and 0xF1 -> gpio_out=8'hA5 after 1 cycle; PORT_IN reads synchronized gpio_in; address 0xE8 write -> no change, read 0x00.
REQ-030 gpio_in[3] 0->1, EDGE_MASK=8'h08 -> EDGE_STAT=8'h08 after SYNC_STAGES+1 cycles, single int_req pulse; write 8'h08 to 0xF2 -> cleared, no pulse.
REQ-031 TMR_RELOAD=3, TMR_CTRL=8'h07 -> count 3,2,1,0, flag and one int_req pulse every 4 cycles after first W1C each period.
REQ-032 Write held 5 cycles to 0xF4 with run=1 -> count loaded once, decrement continues.
REQ-033 Flag W1C coinciding with expiry -> flag remains 1; rst low mid-count -> all outputs zero immediately, no pulse after release.

Source files
------------

// File: rtl/io_pkg.sv
// Shared register map and bit positions for the I/O responder.
package io_pkg;

   // Register offsets within the 8-byte I/O window (io_addr[2:0])
   localparam logic [2:0] REG_PORT_OUT   = 3'd0;
   localparam logic [2:0] REG_PORT_IN    = 3'd1;
   localparam logic [2:0] REG_EDGE_STAT  = 3'd2;
   localparam logic [2:0] REG_EDGE_MASK  = 3'd3;
   localparam logic [2:0] REG_TMR_RELOAD = 3'd4;
   localparam logic [2:0] REG_TMR_CTRL   = 3'd5;
   localparam logic [2:0] REG_TMR_COUNT  = 3'd6;
   localparam logic [2:0] REG_IRQ_STAT   = 3'd7;

   // TMR_CTRL bit positions
   localparam int CTRL_RUN  = 0;
   localparam int CTRL_AUTO = 1;
   localparam int CTRL_IEN  = 2;

   // IRQ_STAT bit positions
   localparam int IRQ_TIMER = 0;
   localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/io_timer.sv
// 8-bit down-counting timer with reload, auto-reload and sticky expire flag.
module io_timer
   import io_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_reload,
   input  logic       wr_ctrl,
   input  logic       clr_flag,
   input  logic [7:0] wdata,
   output logic [7:0] reload,
   output logic [7:0] count,
   output logic [7:0] ctrl,
   output logic       ien,
   output logic       flag
);

   logic run;
   logic auto_rl;
   logic expire;

   // A reload write owns the counter that cycle, so it also masks expiry.
   assign expire = run & (count == 8'h00) & ~wr_reload;

   // Readback image of TMR_CTRL; upper bits read as zero.
   always_comb begin
      ctrl            = 8'h00;
      ctrl[CTRL_RUN]  = run;
      ctrl[CTRL_AUTO] = auto_rl;
      ctrl[CTRL_IEN]  = ien;
   end

   // Reload register and counter: a write loads both, otherwise count down.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reload <= 8'h00;
         count  <= 8'h00;
      end else if (wr_reload) begin
         reload <= wdata;
         count  <= wdata;
      end else if (run) begin
         if (count == 8'h00) count <= auto_rl ? reload : 8'h00;
         else                count <= count - 8'd1;
      end
   end

   // Control bits; one-shot mode drops run on expiry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run     <= 1'b0;
         auto_rl <= 1'b0;
         ien     <= 1'b0;
      end else if (wr_ctrl) begin
         run     <= wdata[CTRL_RUN];
         auto_rl <= wdata[CTRL_AUTO];
         ien     <= wdata[CTRL_IEN];
      end else if (expire && !auto_rl) begin
         run     <= 1'b0;
      end
   end

   // Expire flag: set has priority over a coincident W1C.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          flag <= 1'b0;
      else if (expire)   flag <= 1'b1;
      else if (clr_flag) flag <= 1'b0;
   end

endmodule

// File: rtl/io_responder.sv
// Memory-less I/O peripheral: GPIO out/in, edge detect, timer, interrupt pulse.
module io_responder
   import io_pkg::*;
#(
   parameter logic [7:0] BASE_ADDR   = 8'hF0,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       io_en,
   input  logic       io_wr,
   input  logic [7:0] io_addr,
   input  logic [7:0] io_wdata,
   output logic [7:0] io_rdata,
   output logic       int_req,
   input  logic [7:0] gpio_in,
   output logic [7:0] gpio_out
);

   logic                        sel;
   logic                        wr_act;
   logic                        wr_prev;
   logic                        wr_stb;
   logic [2:0]                  off;
   logic [SYNC_STAGES-1:0][7:0] sync_q;
   logic [7:0]                  port_in;
   logic [7:0]                  port_prev;
   logic [7:0]                  rise;
   logic [7:0]                  edge_stat;
   logic [7:0]                  edge_mask;
   logic [7:0]                  port_out;
   logic [7:0]                  tmr_reload;
   logic [7:0]                  tmr_count;
   logic [7:0]                  tmr_ctrl;
   logic                        tmr_ien;
   logic                        tmr_flag;
   logic                        edge_sum;
   logic                        pending;
   logic                        pend_prev;

   assign sel      = io_en & (io_addr[7:3] == BASE_ADDR[7:3]);
   assign off      = io_addr[2:0];
   assign wr_act   = sel & io_wr;
   // A held write strobe commits only on its first cycle.
   assign wr_stb   = wr_act & ~wr_prev;
   assign port_in  = sync_q[SYNC_STAGES-1];
   assign rise     = port_in & ~port_prev;
   assign edge_sum = |(edge_stat & edge_mask);
   assign pending  = (tmr_flag & tmr_ien) | edge_sum;
   assign gpio_out = port_out;

   // Write-strobe history for edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) wr_prev <= 1'b0;
      else      wr_prev <= wr_act;
   end

   // Multi-flop synchronizer for the asynchronous pins, plus edge history.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q    <= '0;
         port_prev <= 8'h00;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], gpio_in};
         port_prev <= port_in;
      end
   end

   // Edge status (set wins over W1C), edge mask and output port.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         edge_stat <= 8'h00;
         edge_mask <= 8'h00;
         port_out  <= 8'h00;
      end else begin
         if (wr_stb && off == REG_EDGE_STAT) edge_stat <= (edge_stat & ~io_wdata) | rise;
         else                                edge_stat <= edge_stat | rise;
         if (wr_stb && off == REG_EDGE_MASK) edge_mask <= io_wdata;
         if (wr_stb && off == REG_PORT_OUT)  port_out  <= io_wdata;
      end
   end

   io_timer u_timer (
      .clk       (clk),
      .rst       (rst),
      .wr_reload (wr_stb && off == REG_TMR_RELOAD),
      .wr_ctrl   (wr_stb && off == REG_TMR_CTRL),
      .clr_flag  (wr_stb && off == REG_IRQ_STAT && io_wdata[IRQ_TIMER]),
      .wdata     (io_wdata),
      .reload    (tmr_reload),
      .count     (tmr_count),
      .ctrl      (tmr_ctrl),
      .ien       (tmr_ien),
      .flag      (tmr_flag)
   );

   // One-cycle interrupt pulse on each rising edge of the pending condition.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_prev <= 1'b0;
         int_req   <= 1'b0;
      end else begin
         pend_prev <= pending;
         int_req   <= pending & ~pend_prev;
      end
   end

   // Combinational read mux; zero unless a selected read cycle.
   always_comb begin
      io_rdata = 8'h00;
      if (sel && !io_wr) begin
         case (off)
            REG_PORT_OUT:   io_rdata = port_out;
            REG_PORT_IN:    io_rdata = port_in;
            REG_EDGE_STAT:  io_rdata = edge_stat;
            REG_EDGE_MASK:  io_rdata = edge_mask;
            REG_TMR_RELOAD: io_rdata = tmr_reload;
            REG_TMR_CTRL:   io_rdata = tmr_ctrl;
            REG_TMR_COUNT:  io_rdata = tmr_count;
            REG_IRQ_STAT: begin
               io_rdata[IRQ_TIMER] = tmr_flag;
               io_rdata[IRQ_EDGE]  = edge_sum;
            end
            default:        io_rdata = 8'h00;
         endcase
      end
   end

endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder: directed scenarios plus randomized traffic
// against a register-level behavioural model.
module tb_io_responder;

   localparam logic [7:0] BASE = 8'hF0;
   localparam int         S    = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       io_en, io_wr;
   logic [7:0] io_addr, io_wdata, io_rdata, gpio_in, gpio_out;
   logic       int_req;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   io_responder #(.BASE_ADDR(BASE), .SYNC_STAGES(S)) dut (
      .clk(clk), .rst(rst), .io_en(io_en), .io_wr(io_wr), .io_addr(io_addr),
      .io_wdata(io_wdata), .io_rdata(io_rdata), .int_req(int_req),
      .gpio_in(gpio_in), .gpio_out(gpio_out)
   );

   // ---------------- behavioural model ----------------
   logic [7:0] m_out, m_edge, m_mask, m_reload, m_count, m_port_prev;
   logic       m_run, m_auto, m_ien, m_flag, m_pend_prev, m_int, m_wr_prev;
   logic [7:0] m_hist[$];   // last S pin samples; [0] is what software sees

   function automatic void model_reset();
      m_out = 0; m_edge = 0; m_mask = 0; m_reload = 0; m_count = 0; m_port_prev = 0;
      m_run = 0; m_auto = 0; m_ien = 0; m_flag = 0; m_pend_prev = 0; m_int = 0; m_wr_prev = 0;
      m_hist.delete();
      for (int i = 0; i < S; i++) m_hist.push_back(8'h00);
   endfunction

   function automatic logic m_pending();
      return (m_flag && m_ien) || ((m_edge & m_mask) != 8'h00);
   endfunction

   function automatic logic [7:0] m_rdata();
      logic [7:0] r;
      r = 8'h00;
      if (io_en && io_addr[7:3] == BASE[7:3] && !io_wr) begin
         case (io_addr[2:0])
            3'd0: r = m_out;
            3'd1: r = m_hist[0];
            3'd2: r = m_edge;
            3'd3: r = m_mask;
            3'd4: r = m_reload;
            3'd5: r = {5'b0, m_ien, m_auto, m_run};
            3'd6: r = m_count;
            default: r = {6'b0, (m_edge & m_mask) != 8'h00, m_flag};
         endcase
      end
      return r;
   endfunction

   // Advance the model by one clock edge using the inputs presented to it.
   function automatic void model_step();
      logic sel, stb, pend, expire;
      logic [2:0] a;
      logic [7:0] seen, rise;
      sel    = io_en && io_addr[7:3] == BASE[7:3];
      stb    = sel && io_wr && !m_wr_prev;
      a      = io_addr[2:0];
      pend   = m_pending();
      seen   = m_hist[0];
      rise   = seen & ~m_port_prev;
      expire = m_run && m_count == 0 && !(stb && a == 3'd4);
      m_int       = pend && !m_pend_prev;
      m_pend_prev = pend;
      m_wr_prev   = sel && io_wr;
      m_port_prev = seen;
      m_hist.push_back(gpio_in);
      void'(m_hist.pop_front());
      if (stb && a == 3'd2) m_edge = (m_edge & ~io_wdata) | rise;
      else                  m_edge = m_edge | rise;
      if (stb && a == 3'd3) m_mask = io_wdata;
      if (stb && a == 3'd0) m_out  = io_wdata;
      if (expire) m_flag = 1'b1;
      else if (stb && a == 3'd7 && io_wdata[0]) m_flag = 1'b0;
      if (stb && a == 3'd4) begin m_reload = io_wdata; m_count = io_wdata; end
      else if (m_run) m_count = (m_count == 0) ? (m_auto ? m_reload : 8'h00) : m_count - 8'd1;
      if (stb && a == 3'd5) {m_ien, m_auto, m_run} = io_wdata[2:0];
      else if (expire && !m_auto) m_run = 1'b0;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      if (rst) model_step();
      #1;
   endtask

   task automatic idle();
      io_en = 0; io_wr = 0; io_addr = 8'h00; io_wdata = 8'h00;
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int hold);
      io_en = 1; io_wr = 1; io_addr = a; io_wdata = d;
      repeat (hold) tick();
      idle();
      tick();
   endtask

   task automatic do_read(input logic [7:0] a);
      io_en = 1; io_wr = 0; io_addr = a; io_wdata = 8'h00;
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 0; idle(); gpio_in = 8'h00; model_reset();
      repeat (3) tick();
      checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL reset_gpio_out got %h want 00", gpio_out); end
      checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL reset_int_req got %b want 0", int_req); end
      do_read(BASE + 8'd6);
      checks++; if (io_rdata !== 8'h00) begin errors++; $display("FAIL reset_count got %h want 00", io_rdata); end
      idle();
      rst = 1;
      tick();
   endtask

   task automatic test_port();
      do_write(BASE, 8'hA5, 1);
      checks++; if (gpio_out !== 8'hA5) begin errors++; $display("FAIL port_out got %h want a5", gpio_out); end
      gpio_in = 8'h3C;
      repeat (S) tick();
      do_read(BASE + 8'd1);
      checks++; if (io_rdata !== 8'h3C) begin errors++; $display("FAIL port_in got %h want 3c", io_rdata); end
      do_read(BASE);
      checks++; if (io_rdata !== 8'hA5) begin errors++; $display("FAIL port_out_rd got %h want a5", io_rdata); end
      idle();
      do_write(8'hE8, 8'h55, 1);
      checks++; if (gpio_out !== 8'hA5) begin errors++; $display("FAIL out_of_window_wr got %h want a5", gpio_out); end
      do_read(8'hE8);
      checks++; if (io_rdata !== 8'h00) begin errors++; $display("FAIL out_of_window_rd got %h want 00", io_rdata); end
      io_wr = 1; #1;
      checks++; if (io_rdata !== 8'h00) begin errors++; $display("FAIL rdata_during_wr got %h want 00", io_rdata); end
      idle();
   endtask

   task automatic test_edge();
      int pulses;
      gpio_in = 8'h00;
      repeat (S + 2) tick();
      do_write(BASE + 8'd2, 8'hFF, 1);
      do_write(BASE + 8'd3, 8'h08, 1);
      gpio_in = 8'h08;
      repeat (S + 1) tick();
      do_read(BASE + 8'd2);
      checks++; if (io_rdata !== 8'h08) begin errors++; $display("FAIL edge_stat_set got %h want 08", io_rdata); end
      pulses = 0;
      repeat (5) begin tick(); if (int_req === 1'b1) pulses++; end
      checks++; if (pulses != 1) begin errors++; $display("FAIL edge_pulse_count got %0d want 1", pulses); end
      do_write(BASE + 8'd2, 8'h08, 1);
      pulses = 0;
      repeat (4) begin tick(); if (int_req === 1'b1) pulses++; end
      checks++; if (pulses != 0) begin errors++; $display("FAIL edge_clear_pulses got %0d want 0", pulses); end
      do_read(BASE + 8'd2);
      checks++; if (io_rdata !== 8'h00) begin errors++; $display("FAIL edge_stat_clear got %h want 00", io_rdata); end
      idle();
   endtask

   task automatic test_timer();
      logic [7:0] seq [4];
      logic [7:0] exp_seq [4];
      int pulses, m_pulses;
      exp_seq = '{8'd3, 8'd2, 8'd1, 8'd0};
      do_write(BASE + 8'd4, 8'h03, 1);
      io_en = 1; io_wr = 1; io_addr = BASE + 8'd5; io_wdata = 8'h07;
      tick();
      for (int i = 0; i < 4; i++) begin
         do_read(BASE + 8'd6);
         seq[i] = io_rdata;
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (seq[i] !== exp_seq[i]) begin errors++; $display("FAIL tmr_seq[%0d] got %0d want %0d", i, seq[i], exp_seq[i]); end
      end
      pulses = 0; m_pulses = 0;
      for (int i = 0; i < 16; i++) begin
         if (m_flag) begin
            io_en = 1; io_wr = 1; io_addr = BASE + 8'd7; io_wdata = 8'h01;
         end else begin
            do_read(BASE + 8'd6);
            checks++;
            if (io_rdata !== m_rdata()) begin errors++; $display("FAIL tmr_count_run got %h want %h", io_rdata, m_rdata()); end
         end
         tick();
         if (int_req === 1'b1) pulses++;
         if (m_int) m_pulses++;
         checks++;
         if (int_req !== m_int) begin errors++; $display("FAIL tmr_int_req cyc %0d got %b want %b", i, int_req, m_int); end
      end
      checks++; if (pulses != m_pulses || pulses < 3) begin errors++; $display("FAIL tmr_pulses got %0d want %0d", pulses, m_pulses); end
      idle();
   endtask

   task automatic test_back_to_back();
      // held reload write with the timer running: loaded once, then keeps counting
      do_write(BASE + 8'd4, 8'h0A, 5);
      do_read(BASE + 8'd6);
      checks++; if (io_rdata !== 8'd5) begin errors++; $display("FAIL held_write_count got %0d want 5", io_rdata); end
      idle();
   endtask

   task automatic test_w1c_race();
      do_write(BASE + 8'd5, 8'h00, 1);
      do_write(BASE + 8'd7, 8'h01, 1);
      do_write(BASE + 8'd4, 8'h02, 1);
      io_en = 1; io_wr = 1; io_addr = BASE + 8'd5; io_wdata = 8'h03;
      tick();
      idle();
      tick(); tick();
      io_en = 1; io_wr = 1; io_addr = BASE + 8'd7; io_wdata = 8'h01;
      tick();
      idle();
      do_read(BASE + 8'd7);
      checks++; if (io_rdata !== 8'h01) begin errors++; $display("FAIL w1c_race got %h want 01", io_rdata); end
      idle();
      // one-shot started at count 0: flags on the next cycle and stops
      do_write(BASE + 8'd5, 8'h00, 1);
      do_write(BASE + 8'd7, 8'h01, 1);
      do_write(BASE + 8'd4, 8'h00, 1);
      do_write(BASE + 8'd5, 8'h01, 1);
      do_read(BASE + 8'd5);
      checks++; if (io_rdata !== 8'h00) begin errors++; $display("FAIL zero_start_ctrl got %h want 00", io_rdata); end
      do_read(BASE + 8'd7);
      checks++; if (io_rdata !== 8'h01) begin errors++; $display("FAIL zero_start_flag got %h want 01", io_rdata); end
      idle();
   endtask

   task automatic test_reset_mid();
      int pulses;
      do_write(BASE + 8'd7, 8'h01, 1);
      do_write(BASE, 8'h5A, 1);
      do_write(BASE + 8'd4, 8'h50, 1);
      do_write(BASE + 8'd5, 8'h07, 1);
      repeat (3) tick();
      #2 rst = 0; model_reset();
      #1;
      checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL midrst_gpio_out got %h want 00", gpio_out); end
      checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL midrst_int_req got %b want 0", int_req); end
      do_read(BASE + 8'd6);
      checks++; if (io_rdata !== 8'h00) begin errors++; $display("FAIL midrst_count got %h want 00", io_rdata); end
      idle();
      rst = 1;
      pulses = 0;
      repeat (10) begin tick(); if (int_req !== 1'b0) pulses++; end
      checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_pulse_after got %0d want 0", pulses); end
   endtask

   task automatic test_random();
      int op, hold;
      logic [7:0] a;
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 4) == 0) gpio_in = 8'($urandom);
         a  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : (BASE | 8'($urandom_range(0, 7)));
         op = $urandom_range(0, 9);
         io_en = ($urandom_range(0, 9) != 0); io_addr = a;
         if (op < 6) begin
            io_wr = 0; io_wdata = 8'($urandom);
            #1;
            checks++;
            if (io_rdata !== m_rdata()) begin errors++; $display("FAIL rnd_rdata n=%0d addr %h got %h want %h", n, a, io_rdata, m_rdata()); end
            hold = 1;
         end else begin
            io_wr = 1;
            io_wdata = (a[2:0] == 3'd4) ? 8'($urandom_range(0, 12)) : 8'($urandom);
            hold = $urandom_range(1, 3);
         end
         for (int h = 0; h < hold; h++) begin
            tick();
            checks++;
            if (gpio_out !== m_out) begin errors++; $display("FAIL rnd_gpio_out n=%0d got %h want %h", n, gpio_out, m_out); end
            checks++;
            if (int_req !== m_int) begin errors++; $display("FAIL rnd_int_req n=%0d got %b want %b", n, int_req, m_int); end
         end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_port();
      test_edge();
      test_timer();
      test_back_to_back();
      test_w1c_race();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
